// File: rtl/ex_div_pkg.sv
// Shared types and constants for the EX-stage multi-cycle divider.
// The state codes use a fixed 2-bit encoding so they stay stable for downstream decode.
package ex_div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic [2*DIV_WIDTH-1:0] DIV_RESULT_ZERO = '0;

endpackage : ex_div_pkg

// File: rtl/ex_div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left by one, trial-subtract the divisor,
// keep the difference when it is non-negative and shift the outcome bit into the quotient.
module ex_div_step
    import ex_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH-1:0] partial_lo;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             fits;

    // The shifted partial remainder is WIDTH+1 bits; its top bit is rem_i's MSB. When that bit
    // is set the true difference is positive and the low WIDTH bits of diff are already exact.
    assign partial_lo    = {rem_i[WIDTH-2:0], quo_i[WIDTH-1]};
    assign {borrow, diff} = {1'b0, partial_lo} - {1'b0, divisor_i};
    assign fits          = rem_i[WIDTH-1] | ~borrow;

    assign rem_o = fits ? diff : partial_lo;
    assign quo_o = {quo_i[WIDTH-2:0], fits};

endmodule : ex_div_step

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Result {remainder, quotient} is held in END until the pipeline drops start_i.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               cancel_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH-1:0]   op1_abs, op2_abs;
    logic [WIDTH-1:0]   step_rem, step_quo;
    logic [WIDTH-1:0]   rem_fix, quo_fix;

    assign op1_abs = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign op2_abs = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    ex_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    assign rem_fix = r_neg_q ? -step_rem : step_rem;
    assign quo_fix = q_neg_q ? -step_quo : step_quo;

    // Stall is combinational so EX holds in the very cycle a divide is accepted.
    assign busy_o = (state_q == DIV_FREE && start_i && !cancel_i)
                  || state_q == DIV_BYZERO
                  || state_q == DIV_ON;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first; any path that skips an
        // assignment would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        result_d  = result_q;
        ready_d   = ready_q;

        if (cancel_i) begin
            state_d   = DIV_FREE;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = '0;
            divisor_d = '0;
            q_neg_d   = 1'b0;
            r_neg_d   = 1'b0;
            result_d  = DIV_RESULT_ZERO;
            ready_d   = 1'b0;
        end else begin
            unique case (state_q)
                DIV_FREE: begin
                    if (start_i) begin
                        state_d   = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                        cnt_d     = '0;
                        rem_d     = '0;
                        quo_d     = op1_abs;
                        divisor_d = op2_abs;
                        q_neg_d   = signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        r_neg_d   = signed_i && opdata1_i[WIDTH-1];
                    end
                end
                DIV_BYZERO: begin
                    // Division by zero is architecturally unpredictable; report a clean zero.
                    state_d  = DIV_END;
                    result_d = DIV_RESULT_ZERO;
                    ready_d  = 1'b1;
                end
                DIV_ON: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = DIV_END;
                        result_d = {rem_fix, quo_fix};
                        ready_d  = 1'b1;
                    end
                end
                DIV_END: begin
                    if (!start_i) begin
                        state_d  = DIV_FREE;
                        result_d = DIV_RESULT_ZERO;
                        ready_d  = 1'b0;
                    end
                end
                default: state_d = DIV_FREE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            result_q  <= DIV_RESULT_ZERO;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule : ex_div

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed corner cases plus random divides against
// a plain-arithmetic reference for truncating signed/unsigned division.
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        cancel_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    ex_div #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .cancel_i  (cancel_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Truncating division: quotient rounds toward zero, remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Runs one divide with start held, scrambling operands while busy, then holds END for
    // hold_cycles and releases start.
    task automatic run_div(input string tag, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input int hold_cycles);
        logic [63:0] exp;
        int lat_exp;
        int lat;
        int busy_cnt;
        exp      = ref_div(sgn, a, b);
        lat_exp  = (b == 32'd0) ? 2 : 33;
        lat      = 0;
        busy_cnt = 0;
        @(negedge clk);
        start_i   = 1'b1;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        #1;
        if (busy_o) busy_cnt++;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ready_o) begin
                lat = c;
                break;
            end
            if (busy_o) busy_cnt++;
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            signed_i  = 1'($urandom);
        end
        check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(lat_exp));
        check({tag, "_result"}, result_o, exp);
        check({tag, "_busy_in_end"}, 64'(busy_o), 64'd0);
        for (int h = 0; h < hold_cycles; h++) begin
            @(negedge clk);
            check({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
            check({tag, "_hold_result"}, result_o, exp);
        end
        start_i = 1'b0;
        @(negedge clk);
        check({tag, "_release_ready"}, 64'(ready_o), 64'd0);
        check({tag, "_release_result"}, result_o, 64'd0);
    endtask

    initial begin
        int seen_ready;
        rst       = 1'b1;
        start_i   = 1'b0;
        cancel_i  = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b0;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 0);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        run_div("div_by_zero", 1'b1, 32'd1234, 32'd0, 5);
        run_div("divu_small_big", 1'b0, 32'd5, 32'hFFFF_FFFF, 0);

        // Cancel at iteration 10: divider returns to idle and never reports a result.
        @(negedge clk);
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        repeat (10) @(negedge clk);
        start_i  = 1'b0;
        cancel_i = 1'b1;
        @(negedge clk);
        cancel_i = 1'b0;
        check("cancel_ready", 64'(ready_o), 64'd0);
        check("cancel_busy", 64'(busy_o), 64'd0);
        check("cancel_result", result_o, 64'd0);
        seen_ready = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o || busy_o) seen_ready++;
        end
        check("cancel_quiet", 64'(seen_ready), 64'd0);
        run_div("after_cancel", 1'b0, 32'd1000, 32'd3, 0);

        // Reset at iteration 20 clears everything.
        @(negedge clk);
        start_i   = 1'b1;
        signed_i  = 1'b1;
        opdata1_i = 32'hFFFF_0000;
        opdata2_i = 32'd9;
        repeat (20) @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_result", result_o, 64'd0);

        // Start and cancel together: no accept.
        start_i   = 1'b1;
        cancel_i  = 1'b1;
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        #1;
        check("startcancel_busy_now", 64'(busy_o), 64'd0);
        @(negedge clk);
        start_i  = 1'b0;
        cancel_i = 1'b0;
        #1;
        check("startcancel_busy_next", 64'(busy_o), 64'd0);
        check("startcancel_ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        check("startcancel_still_idle", 64'(busy_o), 64'd0);
        check("startcancel_result", result_o, 64'd0);

        // Random divides, biased toward sign and small-divisor corners.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 9));
                1: b = -32'($urandom_range(1, 9));
                2: a = 32'($urandom_range(0, 200));
                default: ;
            endcase
            run_div($sformatf("rand%0d", i), 1'($urandom), a, b, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ex_div
